// File: rtl/wash_program_timer.sv
// Wash/spin phase timer: counts program-dependent durations in prescaled
// time units, with pause, abort on request drop and latched timeout states.
module wash_program_timer #(
    parameter int unsigned PRESCALE = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] program_sel,
    input  logic       cycle_req,
    input  logic       spin_req,
    input  logic       pause,
    output logic       cycle_timeout,
    output logic       spin_timeout,
    output logic       busy,
    output logic [7:0] remaining,
    output logic [1:0] active_prog
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WASH  = 3'd1;
    localparam logic [2:0] ST_SPIN  = 3'd2;
    localparam logic [2:0] ST_WDONE = 3'd3;
    localparam logic [2:0] ST_SDONE = 3'd4;

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  remaining_q, remaining_d;
    logic [1:0]  active_prog_q, active_prog_d;
    logic        cycle_timeout_q, cycle_timeout_d;
    logic        spin_timeout_q, spin_timeout_d;
    logic        busy_q, busy_d;

    logic [7:0]  wash_units;
    logic [7:0]  spin_units;
    logic        phase_req;
    logic        phase_is_wash;

    always_comb begin
        wash_units = 8'd10;
        spin_units = 8'd5;
        case (program_sel)
            2'd0: begin wash_units = 8'd10; spin_units = 8'd5;  end
            2'd1: begin wash_units = 8'd30; spin_units = 8'd10; end
            2'd2: begin wash_units = 8'd60; spin_units = 8'd15; end
            2'd3: begin wash_units = 8'd20; spin_units = 8'd3;  end
            default: begin wash_units = 8'd10; spin_units = 8'd5; end
        endcase
    end

    // The request that keeps the current phase alive.
    assign phase_is_wash = (state_q == ST_WASH) || (state_q == ST_WDONE);
    assign phase_req     = phase_is_wash ? cycle_req : spin_req;

    always_comb begin
        state_d       = state_q;
        presc_d       = presc_q;
        remaining_d   = remaining_q;
        active_prog_d = active_prog_q;
        case (state_q)
            ST_IDLE: begin
                presc_d     = 16'd0;
                remaining_d = 8'd0;
                if (cycle_req) begin
                    state_d       = ST_WASH;
                    remaining_d   = wash_units;
                    active_prog_d = program_sel;
                end else if (spin_req) begin
                    state_d       = ST_SPIN;
                    remaining_d   = spin_units;
                    active_prog_d = program_sel;
                end
            end
            ST_WASH, ST_SPIN: begin
                if (!phase_req) begin
                    state_d     = ST_IDLE;
                    presc_d     = 16'd0;
                    remaining_d = 8'd0;
                end else if (!pause) begin
                    if (presc_q == PRESC_MAX) begin
                        presc_d = 16'd0;
                        if (remaining_q <= 8'd1) begin
                            remaining_d = 8'd0;
                            state_d     = phase_is_wash ? ST_WDONE
                                                        : ST_SDONE;
                        end else begin
                            remaining_d = remaining_q - 8'd1;
                        end
                    end else begin
                        presc_d = presc_q + 16'd1;
                    end
                end
            end
            ST_WDONE, ST_SDONE: begin
                presc_d     = 16'd0;
                remaining_d = 8'd0;
                if (!phase_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                presc_d     = 16'd0;
                remaining_d = 8'd0;
            end
        endcase
        cycle_timeout_d = (state_d == ST_WDONE);
        spin_timeout_d  = (state_d == ST_SDONE);
        busy_d          = (state_d == ST_WASH) || (state_d == ST_SPIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            presc_q         <= 16'd0;
            remaining_q     <= 8'd0;
            active_prog_q   <= 2'd0;
            cycle_timeout_q <= 1'b0;
            spin_timeout_q  <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            presc_q         <= presc_d;
            remaining_q     <= remaining_d;
            active_prog_q   <= active_prog_d;
            cycle_timeout_q <= cycle_timeout_d;
            spin_timeout_q  <= spin_timeout_d;
            busy_q          <= busy_d;
        end
    end

    assign cycle_timeout = cycle_timeout_q;
    assign spin_timeout  = spin_timeout_q;
    assign busy          = busy_q;
    assign remaining     = remaining_q;
    assign active_prog   = active_prog_q;

endmodule

// File: tb/tb_wash_program_timer.sv
// Bench for wash_program_timer: directed scenarios plus random traffic,
// compared every cycle against an elapsed-clock phase model.
module tb_wash_program_timer;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] program_sel;
    logic       cycle_req;
    logic       spin_req;
    logic       pause;
    logic       cycle_timeout;
    logic       spin_timeout;
    logic       busy;
    logic [7:0] remaining;
    logic [1:0] active_prog;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 wash, 2 spin, 3 wash done, 4 spin done.
    int ph;
    int elapsed;
    int units;
    int mprog;
    int wash_t [4] = '{10, 30, 60, 20};
    int spin_t [4] = '{5, 10, 15, 3};

    always #5 clk = ~clk;

    wash_program_timer #(.PRESCALE(P)) dut (
        .clk          (clk),
        .reset        (reset),
        .program_sel  (program_sel),
        .cycle_req    (cycle_req),
        .spin_req     (spin_req),
        .pause        (pause),
        .cycle_timeout(cycle_timeout),
        .spin_timeout (spin_timeout),
        .busy         (busy),
        .remaining    (remaining),
        .active_prog  (active_prog)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    function automatic int exp_remaining();
        if (ph == 1 || ph == 2) return units - elapsed / P;
        return 0;
    endfunction

    task automatic model_update();
        int req;
        if (reset) begin
            ph = 0; elapsed = 0; units = 0; mprog = 0;
            return;
        end
        req = (ph == 1 || ph == 3) ? int'(cycle_req) : int'(spin_req);
        case (ph)
            0: begin
                if (cycle_req) begin
                    ph = 1; units = wash_t[program_sel];
                    elapsed = 0; mprog = program_sel;
                end else if (spin_req) begin
                    ph = 2; units = spin_t[program_sel];
                    elapsed = 0; mprog = program_sel;
                end
            end
            1, 2: begin
                if (req == 0) begin
                    ph = 0;
                end else if (!pause) begin
                    elapsed++;
                    if (elapsed == units * P) ph = (ph == 1) ? 3 : 4;
                end
            end
            default: if (req == 0) ph = 0;
        endcase
    endtask

    task automatic compare_all();
        check("remaining", int'(remaining), exp_remaining());
        check("busy", int'(busy), int'(ph == 1 || ph == 2));
        check("cycle_timeout", int'(cycle_timeout), int'(ph == 3));
        check("spin_timeout", int'(spin_timeout), int'(ph == 4));
        check("active_prog", int'(active_prog), mprog);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic r, input logic c, input logic s,
                         input logic p, input logic [1:0] sel);
        reset = r; cycle_req = c; spin_req = s;
        pause = p; program_sel = sel;
    endtask

    initial begin
        int n;
        ph = 0; elapsed = 0; units = 0; mprog = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        step();
        step();

        // prog 0 wash held through timeout, then released
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        step();
        check("wash_entry_rem", int'(remaining), 10);
        for (int i = 1; i < 40; i++) begin
            program_sel = 2'($urandom);
            step();
        end
        check("wash0_not_done_39", int'(cycle_timeout), 0);
        step();
        check("wash0_done_40", int'(cycle_timeout), 1);
        step();
        cycle_req = 1'b0;
        step();
        check("wash0_idle", int'(busy), 0);

        // prog 3 spin
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
        for (int i = 0; i < 12; i++) step();
        check("spin3_not_done", int'(spin_timeout), 0);
        step();
        check("spin3_done", int'(spin_timeout), 1);
        check("spin3_busy", int'(busy), 0);
        check("spin3_no_ctmo", int'(cycle_timeout), 0);
        spin_req = 1'b0;
        step();

        // prog 1 wash with a 7-clock pause
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        for (int i = 0; i < 50; i++) step();
        pause = 1'b1;
        for (int i = 0; i < 7; i++) step();
        pause = 1'b0;
        for (int i = 0; i < 70; i++) step();
        check("wash1_not_done", int'(cycle_timeout), 0);
        step();
        check("wash1_done_127", int'(cycle_timeout), 1);
        cycle_req = 1'b0;
        step();

        // both requests in the same cycle
        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        step();
        check("both_wash_rem", int'(remaining), 10);
        for (int i = 0; i < 45; i++) step();
        cycle_req = 1'b0;
        step();
        step();
        check("spin_after_idle", int'(remaining), 5);
        spin_req = 1'b0;
        step();

        // prog 2 wash aborted at remaining 30
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        n = 0;
        step();
        while (exp_remaining() != 30 && n < 400) begin
            step();
            n++;
        end
        check("abort_reach30", int'(remaining), 30);
        cycle_req = 1'b0;
        step();
        check("abort_rem0", int'(remaining), 0);
        check("abort_no_tmo", int'(cycle_timeout), 0);

        // reset mid-wash at remaining 5, request still held
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        n = 0;
        step();
        while (exp_remaining() != 5 && n < 100) begin
            step();
            n++;
        end
        check("rst_reach5", int'(remaining), 5);
        reset = 1'b1;
        step();
        check("rst_rem0", int'(remaining), 0);
        reset = 1'b0;
        step();
        check("rst_restart", int'(remaining), 10);
        cycle_req = 1'b0;
        step();

        // random traffic; requests are held steady while paused
        for (int i = 0; i < 4000; i++) begin
            program_sel = 2'($urandom);
            reset = ($urandom_range(0, 499) == 0);
            pause = ($urandom_range(0, 5) == 0);
            if (!pause) begin
                if ($urandom_range(0, 40) == 0) cycle_req = ~cycle_req;
                if ($urandom_range(0, 40) == 0) spin_req = ~spin_req;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
